// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// one full-subtractor cell reused every cycle with a registered borrow.
// A result, borrow-out and signed overflow appear with a one-cycle done
// pulse WIDTH clocks after an accepted start.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    // Holds only the upper WIDTH-1 partial result bits; the bit produced in
    // the final cycle goes straight into diff, so a full-width register
    // would carry a bit that is never read.
    logic [WIDTH-2:0] sd;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             amsb;
    logic             bmsb;

    logic             d;
    logic             nb;
    logic             last;
    logic [WIDTH-1:0] sd_ext;

    // Full-subtractor cell on the current LSBs plus the end-of-operand flag.
    always_comb begin
        d      = sa[0] ^ sb[0] ^ br;
        nb     = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        last   = (cnt == CW'(WIDTH - 1));
        sd_ext = {d, sd};
    end

    // Next-state logic: start only matters in IDLE, RUN ends on the MSB.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register with busy registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
        end
    end

    // Operand load, bit-serial shifting and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            sd   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            amsb <= 1'b0;
            bmsb <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa   <= a;
                        sb   <= b;
                        br   <= bin;
                        cnt  <= '0;
                        amsb <= a[WIDTH-1];
                        bmsb <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    sd  <= sd_ext[WIDTH-1:1];
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    br  <= nb;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        diff <= sd_ext;
                        bout <= nb;
                        ovf  <= (amsb != bmsb) & (d != amsb);
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes the
// expected result and completion cycle, a monitor pops on every done.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    typedef struct {
        int unsigned      due;
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } expect_t;

    expect_t     exp_q[$];
    int unsigned cyc;
    int          vectors;
    int          miscompares;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to check completion latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pops one expectation and compares it.
    always @(negedge clk) begin
        if (done) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_done cycle=%0d diff=%h bout=%b ovf=%b",
                         cyc, diff, bout, ovf);
            end else begin
                expect_t e;
                e = exp_q.pop_front();
                if (cyc != e.due || diff !== e.diff || bout !== e.bout || ovf !== e.ovf) begin
                    miscompares++;
                    $display("[TB] FAIL result cycle=%0d diff=%h bout=%b ovf=%b, required cycle=%0d diff=%h bout=%b ovf=%b",
                             cyc, diff, bout, ovf, e.due, e.diff, e.bout, e.ovf);
                end
            end
        end
    end

    // Drives a one-cycle start from the current (negedge) time; optionally
    // records the hand-computed result expected WIDTH edges after acceptance.
    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vbin, input bit expect_result,
                                 input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
        expect_t e;
        a     = va;
        b     = vb;
        bin   = vbin;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (expect_result) begin
            e.due  = cyc + WIDTH;
            e.diff = ed;
            e.bout = eb;
            e.ovf  = eo;
            exp_q.push_back(e);
        end
        start = 1'b0;
    endtask

    // Compares the visible outputs against constants at the current time.
    task automatic checkOutput(input string name, input logic eb_busy, input logic e_done,
                               input logic [WIDTH-1:0] e_diff, input logic e_bout, input logic e_ovf);
        vectors++;
        if (busy !== eb_busy || done !== e_done || diff !== e_diff || bout !== e_bout || ovf !== e_ovf) begin
            miscompares++;
            $display("[TB] FAIL %s busy=%b done=%b diff=%h bout=%b ovf=%b, required busy=%b done=%b diff=%h bout=%b ovf=%b",
                     name, busy, done, diff, bout, ovf, eb_busy, e_done, e_diff, e_bout, e_ovf);
        end
    endtask

    // Waits, bounded, until every expected result has been seen.
    task automatic waitDrain(input string name);
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s_timeout pending=%0d, required pending=0", name, exp_q.size());
        exp_q.delete();
    endtask

    // Directed sequence.
    initial begin
        bit seen;
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        @(negedge clk);
        applyStimulus(8'h35, 8'h12, 1'b0, 1'b1, 8'h23, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("busy_in_run", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        waitDrain("basic");

        applyStimulus(8'h12, 8'h35, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("hold_during_run", 1'b1, 1'b0, 8'h23, 1'b0, 1'b0);
        waitDrain("negative");

        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
        waitDrain("ovf_neg");
        applyStimulus(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
        waitDrain("ovf_pos");
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        waitDrain("borrow_in");
        @(negedge clk);
        checkOutput("idle_after_done", 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);

        // Start while busy is ignored; then start in the done cycle.
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL busy_start_done_timeout done=0, required done=1");
        end
        applyStimulus(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
        waitDrain("start_in_done");
        repeat (3) @(negedge clk);

        // Reset in the middle of an operation aborts it.
        applyStimulus(8'h35, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_mid_run", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2 * WIDTH) @(negedge clk);
        checkOutput("no_done_after_abort", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(8'h35, 8'h12, 1'b0, 1'b1, 8'h23, 1'b0, 1'b0);
        waitDrain("after_abort");
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
